// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Receive-side signal bundle of the UART peripheral. The
//                receiver (master) consumes the serial line and drives the
//                recovered word, strobes and status; the bus-side logic
//                (slave) sees the reverse directions.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
  parameter int BUS_WIDTH = 8
) ();

  logic                 rx;
  logic [BUS_WIDTH-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;
  logic                 parity_err;

  modport master (
    input  rx,
    output data,
    output valid,
    output frame_err,
    output busy,
    output parity_err
  );

  modport slave (
    output rx,
    input  data,
    input  valid,
    input  frame_err,
    input  busy,
    input  parity_err
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. Oversamples the asynchronous rx line with
//                clk, detects the start edge, samples every bit at its middle
//                and delivers the word with a one-cycle valid strobe plus a
//                frame error flag (bad stop bit).
//                Optional even-parity bit: define UART_RX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int BUS_WIDTH  = 8,
  parameter int UART_SPEED = 115200,
  parameter int CLK_FREQ   = 50000000
) (
  input  wire logic   clk,
  input  wire logic   rst,        // asynchronous, active-low
  uart_rx_if.master   bus
);

  localparam int PULSE_WIDTH = CLK_FREQ / UART_SPEED;
  localparam int HALF        = PULSE_WIDTH / 2;
  localparam int CNT_W       = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam int IDX_W       = $clog2(BUS_WIDTH + 1);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_half = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(BUS_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic                 r_rx_d;

  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [BUS_WIDTH-1:0] r_shift;

  logic [BUS_WIDTH-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;

  logic                 w_cnt_last;
  logic                 w_cnt_half;
  logic                 w_cnt_clr;
  logic                 w_shift_en;
  logic                 w_deliver;
  logic                 w_start_edge;

  assign w_cnt_last   = (r_cnt == c_cnt_last);
  assign w_cnt_half   = (r_cnt == c_cnt_half);
  assign w_start_edge = r_rx_d & ~r_rx_s;

  // Two-flop synchroniser plus one delay stage for falling-edge detection; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic w_par_sample;
  logic r_par_bit;
  logic r_parity_err;
`endif

  // Next-state decode and the datapath strobes that go with each transition.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_deliver   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_sample = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        // Edge-triggered: a line held low (break) never starts a frame.
        if (w_start_edge) begin
          w_state_nxt = ST_START;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_START: begin
        // Mid start bit: still low means a real frame, high means a glitch.
        if (w_cnt_half) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = r_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        // Counter was aligned to mid start bit, so terminal count is mid data bit.
        if (w_cnt_last) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_idx == c_idx_last) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_cnt_last) begin
          w_cnt_clr    = 1'b1;
          w_par_sample = 1'b1;
          w_state_nxt  = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Return to idle at mid stop bit so a back-to-back start edge is caught.
        if (w_cnt_last) begin
          w_cnt_clr   = 1'b1;
          w_deliver   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bit-period counter, bit index and LSB-first shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      if (w_cnt_clr || (r_state == ST_IDLE)) begin
        r_cnt <= '0;
      end else if (!w_cnt_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (r_state != ST_DATA) begin
        r_idx <= '0;
      end else if (w_shift_en) begin
        r_idx <= r_idx + IDX_W'(1);
      end

      if (w_shift_en) begin
        r_shift <= {r_rx_s, r_shift[BUS_WIDTH-1:1]};
      end
    end
  end

  // Delivered word, one-cycle valid strobe and stop-bit check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid <= w_deliver;
      if (w_deliver) begin
        r_data      <= r_shift;
        r_frame_err <= ~r_rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: the parity bit is held until the frame is delivered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_par_sample) begin
        r_par_bit <= r_rx_s;
      end
      if (w_deliver) begin
        r_parity_err <= (^r_shift) ^ r_par_bit;
      end
    end
  end

  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. Frames are driven on rx and
//                their expected word/flags/start time queued; every valid
//                strobe pops one entry and compares it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int PW   = 16;   // 1843200 / 115200
  localparam int HALF = PW / 2;
`ifdef UART_RX_PARITY_EN
  localparam int LAT  = 2 + HALF + 10 * PW;
`else
  localparam int LAT  = 2 + HALF + 9 * PW;
`endif

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    int         start;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  logic prev_valid;
  exp_t q[$];
  exp_t m_e;

  uart_rx_if #(.BUS_WIDTH(8)) bus ();

  uart_rx #(
    .BUS_WIDTH (8),
    .UART_SPEED(115200),
    .CLK_FREQ  (1843200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at a negedge; rx is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    exp_t e;
    e.data  = d;
    e.ferr  = ~stop_bit;
`ifdef UART_RX_PARITY_EN
    e.perr  = (^d) ^ par_bit;
`else
    e.perr  = 1'b0;
`endif
    e.start = cyc;
    q.push_back(e);
    bus.rx = 1'b0;
    wait_neg(PW);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      wait_neg(PW);
    end
`ifdef UART_RX_PARITY_EN
    bus.rx = par_bit;
    wait_neg(PW);
`endif
    bus.rx = stop_bit;
    wait_neg(PW);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, 1'b1, ^d);
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    wait_neg(n);
  endtask

  // Scoreboard: every valid strobe must match the oldest queued frame.
  initial prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst && bus.valid) begin
      if (prev_valid) check("valid_width", 32'd1, 32'd0);
      if (q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        m_e = q.pop_front();
        check("data", {24'd0, bus.data}, {24'd0, m_e.data});
        check("frame_err", {31'd0, bus.frame_err}, {31'd0, m_e.ferr});
        check("parity_err", {31'd0, bus.parity_err}, {31'd0, m_e.perr});
        check($sformatf("latency_%0d_in_window", cyc - m_e.start),
              {31'd0, ((cyc - m_e.start) >= LAT - 1) && ((cyc - m_e.start) <= LAT + 1)},
              32'd1);
      end
    end
    prev_valid = rst & bus.valid;
  end

  // Watchdog: the stimulus never waits on the DUT, this only guards a stuck run.
  initial begin
    #500000;
    $display("FAIL watchdog: cycle %0d reached, limit 50000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    bus.rx  = 1'b1;

    // Reset with rx toggling.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.rx = ~bus.rx;
    end
    @(negedge clk);
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_data", {24'd0, bus.data}, 32'd0);
    check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("rst_parity_err", {31'd0, bus.parity_err}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    bus.rx = 1'b1;
    rst    = 1'b1;
    idle(40);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Nominal frame.
    send_good(8'hA5);
    idle(2 * PW);

    // Start glitch: four clocks low.
    bus.rx = 1'b0;
    wait_neg(4);
    check("glitch_busy_set", {31'd0, bus.busy}, 32'd1);
    bus.rx = 1'b1;
    for (int i = 0; i < HALF + 3; i++) begin
      if (bus.busy) @(negedge clk);
    end
    check("glitch_busy_clear", {31'd0, bus.busy}, 32'd0);
    idle(2 * PW);

    // Bad stop bit followed by a held-low break, then a good frame.
    send_frame(8'h3C, 1'b0, ^8'h3C);
    bus.rx = 1'b0;
    wait_neg(3 * PW);
    check("break_busy", {31'd0, bus.busy}, 32'd0);
    idle(2 * PW);
    send_good(8'h01);
    idle(2 * PW);

    // Back-to-back frames with no idle bits.
    send_good(8'h00);
    send_good(8'hFF);
    for (int i = 0; i < 4; i++) begin
      send_good(8'($urandom_range(0, 255)));
    end
    idle(2 * PW);
    check("queue_drained", q.size(), 32'd0);

    // Reset mid-data discards the frame and clears the held word.
    bus.rx = 1'b0;
    wait_neg(PW);
    bus.rx = 1'b1;
    wait_neg(HALF);
    check("middata_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    wait_neg(3);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_data", {24'd0, bus.data}, 32'd0);
    rst = 1'b1;
    idle(12 * PW);

    send_frame(8'h81, 1'b1, 1'b0);
    idle(2 * PW);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h81, 1'b1, 1'b1);
    idle(2 * PW);
`endif

    check("data_held", {24'd0, bus.data}, 32'h81);
    check("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
